// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU jump-path control blocks.
//   JMP_ABS / JMP_REL / JMP_CALL : JMP_MODE encodings driven to the jump unit
//   state_t                      : call/return sequencer FSM states
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [1:0] JMP_ABS  = 2'b00;  // absolute target
   localparam logic [1:0] JMP_REL  = 2'b01;  // base-relative target
   localparam logic [1:0] JMP_CALL = 2'b11;  // LR-relative target (returns)

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_t;

endpackage

// File: rtl/cpu_call_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_call_ctrl_if
// Request/response bundle between the instruction decoder (master) and the
// call/return sequencer (slave). Signal prefixes are from the sequencer's view.
//   i_pc, i_jmp, i_jmp_rel, i_call, i_ret, i_fault_clr : decoder requests
//   o_jmp_mode, o_ofs_kill, o_taken                     : jump-unit controls
//   o_lr_address                                        : return-stack top
//   o_stack_empty, o_stack_full, o_fault, o_count       : status
// -----------------------------------------------------------------------------
interface cpu_call_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] i_pc;
   logic             i_jmp;
   logic             i_jmp_rel;
   logic             i_call;
   logic             i_ret;
   logic             i_fault_clr;
   logic [1:0]       o_jmp_mode;
   logic             o_ofs_kill;
   logic [WIDTH-1:0] o_lr_address;
   logic             o_taken;
   logic             o_stack_empty;
   logic             o_stack_full;
   logic             o_fault;
   logic [CW-1:0]    o_count;

   modport slave (
      input  i_pc, i_jmp, i_jmp_rel, i_call, i_ret, i_fault_clr,
      output o_jmp_mode, o_ofs_kill, o_lr_address, o_taken,
             o_stack_empty, o_stack_full, o_fault, o_count
   );

   modport master (
      output i_pc, i_jmp, i_jmp_rel, i_call, i_ret, i_fault_clr,
      input  o_jmp_mode, o_ofs_kill, o_lr_address, o_taken,
             o_stack_empty, o_stack_full, o_fault, o_count
   );
endinterface

// File: rtl/cpu_ret_stack.sv
// -----------------------------------------------------------------------------
// cpu_ret_stack
// DEPTH-entry circular return-address stack with a top pointer.
// Build option: CPU_CALL_WRAP_EN -- when defined, a push on a full stack
// overwrites the oldest entry; otherwise a push on full is refused
// (o_push_ok = 0) and the caller must treat it as a fault.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_data : push i_data (ignored when o_push_ok = 0)
//   i_pop          : pop top entry (ignored when empty or pushing)
//   i_clr          : empty the stack
//   o_top          : top entry, 0 when empty
//   o_count        : entries held
//   o_empty/o_full : count == 0 / count == DEPTH
//   o_push_ok      : a push this cycle would be accepted
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module cpu_ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic [CW-1:0]    o_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_push_ok
);

`ifdef CPU_CALL_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_top;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_top_inc;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign o_push_ok = !w_full || WRAP_EN;
   assign w_push    = i_push && o_push_ok;
   assign w_pop     = i_pop && !w_empty && !i_push;
   // DEPTH is a power of two, so the pointer wraps naturally; when full,
   // top+1 is the oldest slot, which is exactly what a wrapping push replaces.
   assign w_top_inc = r_top + PW'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (w_push) begin
         r_top   <= w_top_inc;
         r_count <= w_full ? r_count : r_count + CW'(1);
      end else if (w_pop) begin
         r_top   <= r_top - PW'(1);
         r_count <= r_count - CW'(1);
      end
   end

   // Storage needs no reset: an entry is only visible once it has been pushed.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_clr && w_push)
         r_mem[w_top_inc] <= i_data;
   end

   assign o_top   = w_empty ? '0 : r_mem[r_top];
   assign o_count = r_count;
   assign o_empty = w_empty;
   assign o_full  = w_full;

endmodule

// File: rtl/cpu_call_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_call_ctrl
// Call/return sequencer for the CPU jump unit. Decodes JMP/CALL/RET requests
// (priority RET > CALL > JMP) into JMP_MODE / OFS_KILL / TAKEN, keeps a return
// stack whose top is LR_ADDRESS, and parks in FAULT on stack underflow (and on
// overflow unless CPU_CALL_WRAP_EN is defined) until FAULT_CLR.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : requests in, jump controls and stack status out
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module cpu_call_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   cpu_call_ctrl_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_push;
   logic             w_pop;
   logic             w_clr;
   logic [1:0]       w_mode;
   logic             w_kill;
   logic             w_taken;
   logic [WIDTH-1:0] w_ret_addr;
   logic [WIDTH-1:0] w_top;
   logic [CW-1:0]    w_count;
   logic             w_empty;
   logic             w_full;
   logic             w_push_ok;

   // Return address wraps modulo 2^WIDTH.
   assign w_ret_addr = bus.i_pc + WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode      = JMP_ABS;
      w_kill      = 1'b0;
      w_taken     = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.i_ret) begin
               if (w_empty) begin
                  w_state_nxt = FAULT;
               end else begin
                  // Offset killed so the jump target is exactly LR_ADDRESS.
                  w_mode  = JMP_CALL;
                  w_kill  = 1'b1;
                  w_taken = 1'b1;
                  w_pop   = 1'b1;
               end
            end else if (bus.i_call) begin
               if (w_push_ok) begin
                  w_taken = 1'b1;
                  w_push  = 1'b1;
               end else begin
                  w_state_nxt = FAULT;
               end
            end else if (bus.i_jmp) begin
               w_mode  = {1'b0, bus.i_jmp_rel};
               w_taken = 1'b1;
            end
         end
         FAULT: begin
            if (bus.i_fault_clr) begin
               w_state_nxt = RUN;
               w_clr       = 1'b1;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

   cpu_ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_clr     (w_clr),
      .i_data    (w_ret_addr),
      .o_top     (w_top),
      .o_count   (w_count),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_push_ok (w_push_ok)
   );

   assign bus.o_jmp_mode    = w_mode;
   assign bus.o_ofs_kill    = w_kill;
   assign bus.o_taken       = w_taken;
   assign bus.o_lr_address  = w_top;
   assign bus.o_count       = w_count;
   assign bus.o_stack_empty = w_empty;
   assign bus.o_stack_full  = w_full;
   assign bus.o_fault       = (r_state == FAULT);

endmodule

// File: tb/tb_cpu_call_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_call_ctrl
// Directed vectors for cpu_call_ctrl (WIDTH = 8, DEPTH = 8). Expectations for
// CALL-on-full follow CPU_CALL_WRAP_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_cpu_call_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 i_clk = ~i_clk;

   cpu_call_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   cpu_call_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Apply a request set just after an edge; comb outputs are checked 2ns later.
   task automatic drive(input logic jmp, input logic rel, input logic call,
                        input logic ret, input logic clr, input logic [7:0] pc);
      bus.i_jmp = jmp; bus.i_jmp_rel = rel; bus.i_call = call;
      bus.i_ret = ret; bus.i_fault_clr = clr; bus.i_pc = pc;
      #2;
   endtask

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic chk_ctl(input string tag, input int mode, input int kill, input int taken);
      chk({tag, ".mode"},  bus.o_jmp_mode, mode);
      chk({tag, ".kill"},  bus.o_ofs_kill, kill);
      chk({tag, ".taken"}, bus.o_taken,    taken);
   endtask

   task automatic chk_reset(input string tag);
      chk_ctl(tag, 0, 0, 0);
      chk({tag, ".lr"},    bus.o_lr_address,  0);
      chk({tag, ".count"}, bus.o_count,       0);
      chk({tag, ".empty"}, bus.o_stack_empty, 1);
      chk({tag, ".full"},  bus.o_stack_full,  0);
      chk({tag, ".fault"}, bus.o_fault,       0);
   endtask

   initial begin
      idle();
      i_rst = 1'b1;
      tick(); tick();
      i_rst = 1'b0;
      idle();
      chk_reset("rst");

      // Plain jumps: stack untouched.
      drive(1, 1, 0, 0, 0, 8'h40);
      chk_ctl("jmp_rel", 1, 0, 1);
      tick();
      drive(1, 0, 0, 0, 0, 8'h41);
      chk_ctl("jmp_abs", 0, 0, 1);
      chk("jmp.count", bus.o_count, 0);
      tick();
      idle();
      chk_ctl("idle", 0, 0, 0);
      chk("jmp.count2", bus.o_count, 0);

      // CALL then RET back-to-back.
      drive(0, 0, 1, 0, 0, 8'h10);
      chk_ctl("call10", 0, 0, 1);
      tick();
      drive(0, 0, 0, 1, 0, 8'h50);
      chk("call10.lr",    bus.o_lr_address, 8'h11);
      chk("call10.count", bus.o_count, 1);
      chk("call10.empty", bus.o_stack_empty, 0);
      chk_ctl("ret11", 3, 1, 1);
      tick();
      idle();
      chk("ret11.count", bus.o_count, 0);
      chk("ret11.empty", bus.o_stack_empty, 1);
      chk("ret11.lr",    bus.o_lr_address, 0);

      // PC + 1 wraps.
      drive(0, 0, 1, 0, 0, 8'hFF);
      chk_ctl("callff", 0, 0, 1);
      tick();
      drive(0, 0, 0, 1, 0, 8'h00);
      chk("callff.lr",    bus.o_lr_address, 8'h00);
      chk("callff.count", bus.o_count, 1);
      chk_ctl("ret00", 3, 1, 1);
      tick();
      idle();
      chk("ret00.count", bus.o_count, 0);

      // Underflow fault, frozen state, clear.
      drive(0, 0, 0, 1, 0, 8'h00);
      chk_ctl("ret_empty", 0, 0, 0);
      tick();
      drive(1, 1, 1, 0, 0, 8'h33);
      chk("uf.fault", bus.o_fault, 1);
      chk_ctl("uf.ignored", 0, 0, 0);
      tick();
      chk("uf.count", bus.o_count, 0);
      drive(0, 0, 0, 0, 1, 8'h00);
      chk("uf.fault_hold", bus.o_fault, 1);
      tick();
      idle();
      chk("uf.clr.fault", bus.o_fault, 0);
      chk("uf.clr.count", bus.o_count, 0);

      // Fill the stack.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 1, 0, 0, 8'(i));
         chk($sformatf("fill%0d.taken", i), bus.o_taken, 1);
         tick();
      end
      idle();
      chk("fill.count", bus.o_count, 8);
      chk("fill.full",  bus.o_stack_full, 1);
      chk("fill.lr",    bus.o_lr_address, 8'h08);
      drive(0, 0, 1, 0, 0, 8'h08);
`ifdef CPU_CALL_WRAP_EN
      chk_ctl("call_full", 0, 0, 1);
      tick();
      idle();
      chk("wrap.count", bus.o_count, 8);
      chk("wrap.fault", bus.o_fault, 0);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0, 8'h00);
         chk($sformatf("wrap.lr%0d", i), bus.o_lr_address, 9 - i);
         chk_ctl($sformatf("wrap.ret%0d", i), 3, 1, 1);
         tick();
      end
      idle();
      chk("wrap.drain.count", bus.o_count, 0);
      chk("wrap.drain.empty", bus.o_stack_empty, 1);
`else
      chk_ctl("call_full", 0, 0, 0);
      tick();
      idle();
      chk("of.fault", bus.o_fault, 1);
      chk("of.count", bus.o_count, 8);
      chk("of.lr",    bus.o_lr_address, 8'h08);
      drive(0, 0, 0, 0, 1, 8'h00);
      tick();
      idle();
      chk("of.clr.fault", bus.o_fault, 0);
      chk("of.clr.count", bus.o_count, 0);
`endif

      // FAULT_CLR in RUN has no effect.
      drive(0, 0, 1, 0, 0, 8'h1F);
      tick();
      drive(0, 0, 0, 0, 1, 8'h00);
      chk_ctl("clr_run", 0, 0, 0);
      tick();
      idle();
      chk("clr_run.count", bus.o_count, 1);
      chk("clr_run.lr",    bus.o_lr_address, 8'h20);

      // All three requests together: RET wins.
      drive(1, 1, 1, 1, 0, 8'h70);
      chk_ctl("prio", 3, 1, 1);
      chk("prio.lr", bus.o_lr_address, 8'h20);
      tick();
      idle();
      chk("prio.count", bus.o_count, 0);
      chk("prio.empty", bus.o_stack_empty, 1);

      // Fault, then reset wins over FAULT_CLR and requests.
      drive(0, 0, 0, 1, 0, 8'h00);
      tick();
      idle();
      chk("rf.fault", bus.o_fault, 1);
      i_rst = 1'b1;
      drive(1, 0, 1, 0, 1, 8'h55);
      tick();
      i_rst = 1'b0;
      idle();
      chk_reset("rst2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
